// File: rtl/ls_queue_pkg.sv
// Shared constants for the load/store queue: op encodings, label base, FSM states.
// Pure declarations; no latency or flow control of its own.
package ls_queue_pkg;

  localparam logic opLW = 1'b0;
  localparam logic opSW = 1'b1;

  localparam int LS_LABEL_BASE = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    CDB  = 2'd2
  } ls_state_t;

endpackage

// File: rtl/ls_data_ram.sv
// Word-addressed data RAM: synchronous write, registered read, async clear.
// Read data appears one edge after re; rdata holds until the next read.
module ls_data_ram #(
  parameter int WORDS  = 64,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue; a ready lw issued at E0 raises require after E2, sw retires at E2.
// Issue is refused while full; the head holds require/dataOut/labelOut until requireAC.
module ls_queue
  import ls_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int LABEL_W    = 4,
  parameter int LABEL_BASE = LS_LABEL_BASE,
  parameter int MEM_WORDS  = 64
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               WEN,
  input  logic               opIn,
  input  logic [DATA_W-1:0]  dataIn1,
  input  logic [LABEL_W-1:0] label1,
  input  logic [DATA_W-1:0]  dataIn2,
  input  logic [LABEL_W-1:0] label2,
  input  logic [15:0]        immd16,
  input  logic               BCEN,
  input  logic [LABEL_W-1:0] BClabel,
  input  logic [DATA_W-1:0]  BCdata,
  input  logic               requireAC,
  output logic               isFull,
  output logic [LABEL_W-1:0] writeable_labelOut,
  output logic               require,
  output logic [DATA_W-1:0]  dataOut,
  output logic [LABEL_W-1:0] labelOut
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MEM_WORDS);

  logic [PW-1:0]      head, tail;
  logic [PW:0]        count;
  ls_state_t          state;
  logic [AW-1:0]      mem_idx;

  logic [DEPTH-1:0]   e_op;
  logic [DATA_W-1:0]  e_bval [DEPTH];
  logic [LABEL_W-1:0] e_blab [DEPTH];
  logic [DATA_W-1:0]  e_off  [DEPTH];
  logic [DATA_W-1:0]  e_sval [DEPTH];
  logic [LABEL_W-1:0] e_slab [DEPTH];

  logic [DEPTH-1:0]   occ;
  logic               bc_live, snoop1, snoop2;
  logic               push, pop, head_rdy, ram_we, ram_re;

  assign isFull             = (count == (PW+1)'(DEPTH));
  assign writeable_labelOut = LABEL_W'(LABEL_BASE) + LABEL_W'(tail);

  assign push     = WEN && !isFull;
  assign head_rdy = (count != '0) && (e_blab[head] == '0) &&
                    ((e_op[head] == opLW) || (e_slab[head] == '0));
  assign ram_we   = (state == MEM) && (e_op[head] == opSW);
  assign ram_re   = (state == MEM) && (e_op[head] == opLW);
  assign pop      = ram_we || ((state == CDB) && requireAC);

  // Label 0 means "no producer", so a broadcast on tag 0 never matches anything.
  assign bc_live = BCEN && (BClabel != '0);
  assign snoop1  = bc_live && (label1 == BClabel);
  assign snoop2  = bc_live && (label2 == BClabel);

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++)
      occ[i] = ({1'b0, PW'(i) - head} < count);
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      e_op <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_bval[i] <= '0;
        e_blab[i] <= '0;
        e_off[i]  <= '0;
        e_sval[i] <= '0;
        e_slab[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bc_live && occ[i] && (e_blab[i] == BClabel)) begin
          e_bval[i] <= BCdata;
          e_blab[i] <= '0;
        end
        if (bc_live && occ[i] && (e_slab[i] == BClabel)) begin
          e_sval[i] <= BCdata;
          e_slab[i] <= '0;
        end
      end
      if (push) begin
        e_op[tail]   <= opIn;
        e_bval[tail] <= snoop1 ? BCdata : dataIn1;
        e_blab[tail] <= snoop1 ? '0 : label1;
        e_off[tail]  <= DATA_W'($signed(immd16));
        e_sval[tail] <= snoop2 ? BCdata : dataIn2;
        e_slab[tail] <= snoop2 ? '0 : label2;
      end
    end
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      state    <= IDLE;
      mem_idx  <= '0;
      require  <= 1'b0;
      labelOut <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: if (head_rdy) begin
          // Byte address wraps at DATA_W; only the word index inside the RAM is kept.
          mem_idx <= AW'((e_bval[head] + e_off[head]) >> 2);
          state   <= MEM;
        end
        MEM: begin
          if (e_op[head] == opSW) begin
            state <= IDLE;
          end else begin
            labelOut <= LABEL_W'(LABEL_BASE) + LABEL_W'(head);
            require  <= 1'b1;
            state    <= CDB;
          end
        end
        CDB: if (requireAC) begin
          require <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ls_data_ram #(
    .WORDS  (MEM_WORDS),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (nRST),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (mem_idx),
    .wdata (e_sval[head]),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_ls_queue.sv
// Scenario bench for ls_queue: a scoreboard of expected load results is drained
// by a grant monitor; each task also checks its own timing and flag behaviour.
module tb_ls_queue;

  logic        clk = 1'b0;
  logic        nRST;
  logic        WEN, opIn, BCEN, requireAC;
  logic [31:0] dataIn1, dataIn2, BCdata;
  logic [3:0]  label1, label2, BClabel;
  logic [15:0] immd16;
  logic        isFull, require;
  logic [3:0]  writeable_labelOut, labelOut;
  logic [31:0] dataOut;

  typedef struct {
    logic [3:0]  lab;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_mem [64];
  logic [1:0]  exp_tail;
  int          errors = 0;
  int          checks = 0;

  ls_queue dut (
    .clk                (clk),
    .nRST               (nRST),
    .WEN                (WEN),
    .opIn               (opIn),
    .dataIn1            (dataIn1),
    .label1             (label1),
    .dataIn2            (dataIn2),
    .label2             (label2),
    .immd16             (immd16),
    .BCEN               (BCEN),
    .BClabel            (BClabel),
    .BCdata             (BCdata),
    .requireAC          (requireAC),
    .isFull             (isFull),
    .writeable_labelOut (writeable_labelOut),
    .require            (require),
    .dataOut            (dataOut),
    .labelOut           (labelOut)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  // A granted broadcast is consumed at the next rising edge; compare it here.
  always @(negedge clk) begin
    if (!nRST && require && requireAC) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: label=%0d data=%h, required no load pending", labelOut, dataOut);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dataOut !== e.dat || labelOut !== e.lab) begin
          errors++;
          $display("FAIL load_result: label=%0d data=%h, required label=%0d data=%h",
                   labelOut, dataOut, e.lab, e.dat);
        end
      end
    end
  end

  function automatic int widx(input logic [31:0] base, input logic [15:0] imm);
    logic [31:0] a;
    a = base + {{16{imm[15]}}, imm};
    return int'(a[7:2]);
  endfunction

  function automatic logic [3:0] lab_of(input logic [1:0] slot);
    return 4'd9 + {2'b00, slot};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [31:0] d1, input logic [3:0] l1,
                       input logic [31:0] d2, input logic [3:0] l2, input logic [15:0] imm);
    WEN = 1'b1; opIn = op; dataIn1 = d1; label1 = l1;
    dataIn2 = d2; label2 = l2; immd16 = imm;
    tick();
    WEN = 1'b0;
    exp_tail = exp_tail + 2'd1;
  endtask

  task automatic push_lw(input logic [3:0] lab, input int idx);
    exp_t e;
    e.lab = lab;
    e.dat = mdl_mem[idx];
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d loads outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1; WEN = 1'b0; opIn = 1'b0; BCEN = 1'b0; requireAC = 1'b0;
    dataIn1 = '0; dataIn2 = '0; BCdata = '0; label1 = '0; label2 = '0; BClabel = '0; immd16 = '0;
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    exp_tail = 2'd0;
    tick(); tick();
    checks++;
    if (require !== 1'b0 || dataOut !== 32'h0 || labelOut !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: require=%b data=%h label=%0d, required 0/0/0", require, dataOut, labelOut);
    end
    checks++;
    if (isFull !== 1'b0 || writeable_labelOut !== 4'd9) begin
      errors++;
      $display("FAIL reset_flags: isFull=%b wlabel=%0d, required 0/9", isFull, writeable_labelOut);
    end
    nRST = 1'b0;
    tick();
  endtask

  task automatic test_sw_lw();
    requireAC = 1'b1;
    issue(1'b1, 32'h10, 4'd0, 32'hDEADBEEF, 4'd0, 16'd4);
    mdl_mem[widx(32'h10, 16'd4)] = 32'hDEADBEEF;
    push_lw(lab_of(exp_tail), widx(32'h10, 16'd4));
    issue(1'b0, 32'h10, 4'd0, 32'h0, 4'd0, 16'd4);
    checks++;
    if (isFull !== 1'b0) begin
      errors++;
      $display("FAIL sw_lw_full: isFull=%b, required 0", isFull);
    end
    drain("sw_lw");
  endtask

  task automatic test_pending_base();
    logic [3:0] lab;
    requireAC = 1'b1;
    issue(1'b1, 32'h20, 4'd0, 32'h55, 4'd0, 16'd0);
    mdl_mem[8] = 32'h55;
    repeat (5) tick();
    lab = lab_of(exp_tail);
    push_lw(lab, 8);
    issue(1'b0, 32'h0, 4'd3, 32'h0, 4'd0, 16'd0);
    tick(); tick();
    checks++;
    if (require !== 1'b0) begin
      errors++;
      $display("FAIL pending_early: require=%b, required 0 before broadcast", require);
    end
    BCEN = 1'b1; BClabel = 4'd3; BCdata = 32'h20;
    tick();
    BCEN = 1'b0; BClabel = 4'd0; BCdata = '0;
    checks++;
    if (require !== 1'b0) begin
      errors++;
      $display("FAIL pending_bc0: require=%b, required 0", require);
    end
    tick();
    checks++;
    if (require !== 1'b0) begin
      errors++;
      $display("FAIL pending_bc1: require=%b, required 0", require);
    end
    tick();
    checks++;
    if (require !== 1'b1 || dataOut !== 32'h55 || labelOut !== lab) begin
      errors++;
      $display("FAIL pending_bc2: require=%b data=%h label=%0d, required 1/%h/%0d",
               require, dataOut, labelOut, 32'h55, lab);
    end
    drain("pending");
  endtask

  task automatic test_full();
    logic [15:0] imms [4];
    imms[0] = 16'h0014; imms[1] = 16'h0020; imms[2] = 16'hFFFC; imms[3] = 16'h0014;
    requireAC = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (writeable_labelOut !== lab_of(exp_tail) || isFull !== 1'b0) begin
        errors++;
        $display("FAIL full_fill%0d: wlabel=%0d isFull=%b, required %0d/0",
                 k, writeable_labelOut, isFull, lab_of(exp_tail));
      end
      push_lw(lab_of(exp_tail), widx(32'h100, imms[k]));
      issue(1'b0, 32'h0, 4'd5, 32'h0, 4'd0, imms[k]);
    end
    checks++;
    if (isFull !== 1'b1 || writeable_labelOut !== 4'd9) begin
      errors++;
      $display("FAIL full_flag: isFull=%b wlabel=%0d, required 1/9", isFull, writeable_labelOut);
    end
    WEN = 1'b1; opIn = 1'b0; label1 = 4'd0; dataIn1 = 32'h0; immd16 = 16'h0;
    tick();
    WEN = 1'b0;
    checks++;
    if (isFull !== 1'b1 || writeable_labelOut !== 4'd9) begin
      errors++;
      $display("FAIL full_drop: isFull=%b wlabel=%0d, required 1/9", isFull, writeable_labelOut);
    end
    requireAC = 1'b1;
    BCEN = 1'b1; BClabel = 4'd5; BCdata = 32'h100;
    tick();
    BCEN = 1'b0; BClabel = 4'd0; BCdata = '0;
    drain("full");
    checks++;
    if (isFull !== 1'b0) begin
      errors++;
      $display("FAIL full_after_drain: isFull=%b, required 0", isFull);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [3:0] lab;
    requireAC = 1'b0;
    lab = lab_of(exp_tail);
    push_lw(lab, widx(32'h10, 16'd4));
    issue(1'b0, 32'h10, 4'd0, 32'h0, 4'd0, 16'd4);
    push_lw(lab_of(exp_tail), widx(32'h20, 16'd0));
    issue(1'b0, 32'h20, 4'd0, 32'h0, 4'd0, 16'd0);
    n = 0;
    while (require !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (require !== 1'b1) begin
      errors++;
      $display("FAIL bp_request: require=%b, required 1", require);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (require !== 1'b1 || dataOut !== 32'hDEADBEEF || labelOut !== lab) begin
        errors++;
        $display("FAIL bp_hold%0d: require=%b data=%h label=%0d, required 1/%h/%0d",
                 k, require, dataOut, labelOut, 32'hDEADBEEF, lab);
      end
    end
    requireAC = 1'b1;
    tick();
    checks++;
    if (sb.size() != 1) begin
      errors++;
      $display("FAIL bp_grant_pop: pending=%0d, required 1", sb.size());
    end
    drain("bp");
  endtask

  task automatic test_same_cycle_snoop();
    requireAC = 1'b1;
    BCEN = 1'b1; BClabel = 4'd6; BCdata = 32'h40;
    issue(1'b1, 32'h0, 4'd6, 32'h12345678, 4'd0, 16'd0);
    mdl_mem[16] = 32'h12345678;
    push_lw(lab_of(exp_tail), 16);
    issue(1'b0, 32'h0, 4'd6, 32'h0, 4'd0, 16'd0);
    BCEN = 1'b0; BClabel = 4'd0; BCdata = '0;
    drain("snoop");
  endtask

  task automatic test_reset_mid();
    int n;
    requireAC = 1'b0;
    for (int k = 0; k < 3; k++) issue(1'b0, 32'h10, 4'd0, 32'h0, 4'd0, 16'd4);
    n = 0;
    while (require !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (require !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_request: require=%b, required 1", require);
    end
    nRST = 1'b1;
    #1;
    checks++;
    if (require !== 1'b0 || dataOut !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: require=%b data=%h, required 0/0", require, dataOut);
    end
    checks++;
    if (isFull !== 1'b0 || writeable_labelOut !== 4'd9) begin
      errors++;
      $display("FAIL rst_mid_state: isFull=%b wlabel=%0d, required 0/9", isFull, writeable_labelOut);
    end
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    exp_tail = 2'd0;
    tick();
    nRST = 1'b0;
    tick();
    requireAC = 1'b1;
    push_lw(lab_of(exp_tail), widx(32'h10, 16'd4));
    issue(1'b0, 32'h10, 4'd0, 32'h0, 4'd0, 16'd4);
    drain("rst_mid");
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_pending_base();
    test_full();
    test_backpressure();
    test_same_cycle_snoop();
    test_reset_mid();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
